// File: rtl/apb_master_arbiter.sv
`timescale 1ns/1ps
// apb_master_arbiter: round-robin APB master shared by two single-transfer requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT cycles.
module apb_master_arbiter #(
  parameter int ADDRWIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 m0_req,
  input  logic [ADDRWIDTH-1:0] m0_addr,
  input  logic                 m0_write,
  input  logic [31:0]          m0_wdata,
  input  logic [3:0]           m0_strb,
  output logic                 m0_done,
  output logic [31:0]          m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic [ADDRWIDTH-1:0] m1_addr,
  input  logic                 m1_write,
  input  logic [31:0]          m1_wdata,
  input  logic [3:0]           m1_strb,
  output logic                 m1_done,
  output logic [31:0]          m1_rdata,
  output logic                 m1_err,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        owner;
  logic        pick_m1;
  logic        fin;
  logic        fin_err;
  logic [31:0] fin_rdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign PPROT = 3'b000;

  // On a tie the requester that did not win last time gets the bus.
  assign pick_m1 = m1_req & (~m0_req | ~last_grant);

  always_comb begin
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    if (state == ACCESS) begin
      if (PREADY) begin
        fin       = 1'b1;
        fin_err   = PSLVERR;
        fin_rdata = PWRITE ? 32'h0 : PRDATA;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (tmo_cnt == TMO_LAST) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      m0_done    <= 1'b0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_done    <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            owner  <= pick_m1;
            PSEL   <= 1'b1;
            PADDR  <= pick_m1 ? m1_addr : m0_addr;
            PWRITE <= pick_m1 ? m1_write : m0_write;
            PWDATA <= pick_m1 ? m1_wdata : m0_wdata;
            PSTRB  <= pick_m1 ? (m1_write ? m1_strb : 4'h0)
                              : (m0_write ? m0_strb : 4'h0);
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
`ifdef APB_ARB_TIMEOUT_EN
          if (!PREADY) tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (fin) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= DONE;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rdata <= fin_rdata;
              m1_err   <= fin_err;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= fin_rdata;
              m0_err   <= fin_err;
            end
          end
        end
        DONE: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
`timescale 1ns/1ps
// tb_apb_master_arbiter: scoreboard bench for the round-robin APB master.
// Completions are predicted when commands are issued and compared on each done pulse.
module tb_apb_master_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        m0_req, m0_write, m0_done, m0_err;
  logic [15:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_strb;
  logic        m1_req, m1_write, m1_done, m1_err;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_strb;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        tb_last;
  int          slv_wait;
  logic [31:0] slv_rdata;
  logic        slv_err;

  apb_master_arbiter #(.ADDRWIDTH(16), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_strb(m0_strb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_strb(m1_strb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Slave model: PREADY low for slv_wait ACCESS cycles, then responds.
  initial begin : slave
    int scnt;
    scnt = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (scnt < slv_wait) begin
          PREADY = 1'b0; PRDATA = 32'hBAD0_0000; PSLVERR = 1'b0;
          scnt++;
        end else begin
          PREADY = 1'b1; PRDATA = slv_rdata; PSLVERR = slv_err;
        end
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; scnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (m0_done || m1_done) begin
        chk("dual_done", m0_done & m1_done, 1'b0);
        if (sb_q.size() == 0) begin
          chk("spurious_done", {m1_done, m0_done}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          chk("done_who", m1_done, e.who);
          chk("rdata", m1_done ? m1_rdata : m0_rdata, e.rdata);
          chk("err", m1_done ? m1_err : m0_err, e.err);
        end
      end
    end
  end

  task automatic drive_req(input logic who, input logic val, input logic [15:0] addr,
                           input logic wr, input logic [31:0] wd, input logic [3:0] st);
    if (!who) begin
      m0_req = val; m0_addr = addr; m0_write = wr; m0_wdata = wd; m0_strb = st;
    end else begin
      m1_req = val; m1_addr = addr; m1_write = wr; m1_wdata = wd; m1_strb = st;
    end
  endtask

  task automatic issue(input logic who, input logic [15:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st, input int waits,
                       input logic [31:0] srd, input logic serr,
                       input logic [31:0] erd, input logic eerr, input int lat);
    exp_t e;
    int   cyc;
    logic seen;
    @(negedge PCLK);
    slv_wait = waits; slv_rdata = srd; slv_err = serr;
    e.who = who; e.rdata = erd; e.err = eerr;
    sb_q.push_back(e);
    drive_req(who, 1'b1, addr, wr, wd, st);
    @(posedge PCLK); #1;
    chk("setup_phase", {PSEL, PENABLE}, 2'b10);
    chk("setup_addr", PADDR, addr);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pstrb", PSTRB, wr ? st : 4'h0);
    if (wr) chk("setup_pwdata", PWDATA, wd);
    @(posedge PCLK); #1;
    chk("access_phase", {PSEL, PENABLE}, 2'b11);
    cyc = 2; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge PCLK); #1;
      cyc++;
      seen = who ? m1_done : m0_done;
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("latency", cyc, lat);
      chk("done_psel", {PSEL, PENABLE}, 2'b00);
    end
    @(posedge PCLK); #1;
    drive_req(who, 1'b0, addr, wr, wd, st);
    tb_last = who;
  endtask

  // Both requesters hold req; each winner re-requests right after its done.
  task automatic tie_run(input int rounds);
    exp_t e;
    int   cyc;
    logic seen;
    logic w;
    @(negedge PCLK);
    slv_wait = 0; slv_rdata = 32'h0000_1234; slv_err = 1'b0;
    drive_req(1'b0, 1'b1, 16'h3000, 1'b1, 32'h1111_2222, 4'h3);
    drive_req(1'b1, 1'b1, 16'h3004, 1'b0, 32'h0, 4'hF);
    for (int r = 0; r < rounds; r++) begin
      w = tb_last ? 1'b0 : 1'b1;
      e.who = w; e.rdata = w ? 32'h0000_1234 : 32'h0; e.err = 1'b0;
      sb_q.push_back(e);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 20) begin
        @(posedge PCLK); #1;
        cyc++;
        seen = m0_done | m1_done;
      end
      chk("tie_done_seen", seen, 1'b1);
      chk("tie_winner", m1_done, w);
      tb_last = w;
      @(posedge PCLK); #1;
      if (r == rounds - 1) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end else begin
        if (w) m1_req = 1'b0; else m0_req = 1'b0;
        @(negedge PCLK);
        if (w) m1_req = 1'b1; else m0_req = 1'b1;
      end
    end
  endtask

  initial begin : main
    PRESET = 1'b1; tb_last = 1'b1;
    slv_wait = 0; slv_rdata = '0; slv_err = 1'b0;
    drive_req(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0);
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr", PADDR, 16'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pstrb_pprot", {PSTRB, PPROT}, 7'h0);
    chk("rst_done_err", {m0_done, m1_done, m0_err, m1_err}, 4'h0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    @(negedge PCLK); PRESET = 1'b0;

    issue(1'b0, 16'h1004, 1'b1, 32'h0000_00A5, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 3);
    issue(1'b1, 16'h2000, 1'b0, 32'h5555_5555, 4'hF, 3, 32'h0000_00C3, 1'b0, 32'h0000_00C3, 1'b0, 6);
    tie_run(4);
    issue(1'b0, 16'h1010, 1'b0, 32'h0, 4'h0, 1, 32'h0000_55AA, 1'b1, 32'h0000_55AA, 1'b1, 4);
    chk("m1_rdata_held", m1_rdata, 32'h0000_1234);
    chk("m1_err_held", m1_err, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
    issue(1'b0, 16'h4000, 1'b0, 32'h0, 4'h0, 100, 32'h0000_0077, 1'b0, 32'h0, 1'b1, 6);
    issue(1'b0, 16'h4004, 1'b0, 32'h0, 4'h0, 3, 32'h0000_0099, 1'b0, 32'h0000_0099, 1'b0, 6);
`endif

    // Reset during ACCESS: bus released at once, no completion, tie priority restored.
    issue(1'b0, 16'h1020, 1'b1, 32'h0000_0042, 4'h1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3);
    @(negedge PCLK);
    slv_wait = 20;
    drive_req(1'b1, 1'b1, 16'h2008, 1'b0, 32'h0, 4'h0);
    @(posedge PCLK); @(posedge PCLK); #1;
    chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("rst_async_psel", {PSEL, PENABLE}, 2'b00);
    @(posedge PCLK); #1;
    m1_req = 1'b0;
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    tb_last = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("post_rst_idle", PSEL, 1'b0);
    tie_run(2);

    repeat (4) @(posedge PCLK);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares the peripheral APB bus (UART, GPIO A/B slave mux) between the AHB-to-APB bridge side and a second on-chip requester (DMA or debug). Each requester issues a single-transfer command through a req/done handshake. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases, and returns read data and error status to the winner. It sits on PCLK, directly upstream of the APB slave multiplexer.

## Interface
- ADDRWIDTH, 16, width of PADDR and requester addresses
- TIMEOUT, 255, ACCESS-phase cycles without PREADY before abort (used only with APB_ARB_TIMEOUT_EN)

- PCLK  in  1  APB clock; all state on rising edge
- PRESET  in  1  asynchronous active-high reset
- m0_req / m1_req  in  1 each  command valid; held high until matching done
- m0_addr / m1_addr  in  ADDRWIDTH each  byte address
- m0_write / m1_write  in  1 each  1 = write
- m0_wdata / m1_wdata  in  32 each  write data
- m0_strb / m1_strb  in  4 each  write byte strobes
- m0_done / m1_done  out  1 each  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32 each  read data, valid with done
- m0_err / m1_err  out  1 each  error, valid with done
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  ADDRWIDTH  APB address
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB strobes (forced 0 on reads)
- PPROT  out  3  tied 3'b000
- PRDATA  in  32  read data from slave mux
- PREADY, PSLVERR  in  1 each  slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester not granted last. last_grant resets to 1, so m0 wins the first tie.
- Grant captures addr/write/wdata/strb into the APB output registers and enters SETUP. Requester inputs are not sampled again until the next IDLE.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Wait states are held while PREADY=0. With PREADY=1, register PRDATA (PWDATA-agnostic; rdata forced 0 on writes) and PSLVERR, then enter DONE.
- DONE: PSEL=0, PENABLE=0. The granted mN_done=1 with mN_rdata/mN_err. Update last_grant. Return to IDLE.
- Requesters must drop req in the cycle after sampling done. A req still high in IDLE is treated as a new command.
- mN_rdata/mN_err hold their value until the next done for that requester.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Reset values: PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, PSTRB, PPROT = 0; all done/err = 0; rdata = 0; state IDLE; last_grant = 1; timeout counter = 0.
- PRESET asserted mid-transfer clears everything asynchronously. PSEL drops at once and no done is issued.
- Zero-wait latency: req high at edge 0 (IDLE) → SETUP after edge 1 → ACCESS after edge 2 → done high after edge 3. Each PREADY=0 cycle adds 1.
- Minimum spacing is 4 cycles per transfer, because IDLE occurs between every pair of transfers. Back-to-back ACCESS phases never happen.
- A req that drops during SETUP/ACCESS is ignored. The transfer completes and done still pulses.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - An 8-bit-minimum counter (width clog2(TIMEOUT+1)) clears on SETUP entry and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, the FSM enters DONE with err=1, rdata=0, and PSEL/PENABLE dropped.
  - A PREADY arriving in the same cycle as the limit wins, giving a normal completion.
- APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits on PREADY indefinitely; the TIMEOUT parameter is unused.

## Test plan
- m0 write to 0x1004, data 0xA5, strb 0xF, PREADY=1: PSEL at cycle 1, PENABLE at cycle 2, m0_done=1 at cycle 3, m0_err=0, PWRITE=1, PSTRB=0xF.
- m1 read of 0x2000 with PREADY low for 3 cycles, PRDATA 0x0000_00C3: m1_done at cycle 6, m1_rdata=0xC3, PSTRB=0.
- m0 and m1 requesting together, both re-requesting after done: grant order m0, m1, m0, m1, with no done on the ungranted requester.
- PSLVERR=1 with PREADY: mN_err=1 and rdata still registered. PRESET pulsed in ACCESS: PSEL=0 immediately, no done, next m1 tie still goes to m0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=4, PREADY held 0: done with err=1, rdata=0 after the 4th ACCESS cycle, PSEL low the same cycle. PREADY=1 on the 4th cycle gives err=0.
